// File: rtl/ahb_lite_cmd_master_if.sv
// Command/response and AHB-Lite bus bundle for ahb_lite_cmd_master.
// The master modport is the initiator view; the slave modport is the environment view.
interface ahb_lite_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer initiator: valid/ready command in, NONSEQ word transfer out, one-cycle response.
// Optional wait-state abort enabled by defining AHBM_TIMEOUT_EN.
module ahb_lite_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb_lite_cmd_master_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef AHBM_TIMEOUT_EN
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef AHBM_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = 8'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d  = S_ADDR;
                    htrans_d = 2'b10;
                    haddr_d  = {bus.cmd_addr[31:2], 2'b00};
                    hwrite_d = bus.cmd_write;
                    wdata_d  = bus.cmd_wdata;
                    err_d    = 1'b0;
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = 2'b00;
                    hwdata_d = hwrite_q ? wdata_q : 32'd0;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR arrives with HREADY low; remember it.
                if (bus.HRESP) err_d = 1'b1;
                if (bus.HREADY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q | bus.HRESP;
                    rsp_rdata_d = (!hwrite_q && !(err_q | bus.HRESP)) ? bus.HRDATA : 32'd0;
`ifdef AHBM_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AHBM_TIMEOUT_EN
        // Abort overrides everything once the stall reaches the limit.
        if ((state_q == S_ADDR || state_q == S_DATA) && !bus.HREADY) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d == 8'(TIMEOUT_CYCLES)) begin
                state_d       = S_IDLE;
                htrans_d      = 2'b00;
                rsp_valid_d   = 1'b1;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b1;
                rsp_rdata_d   = 32'd0;
                wait_cnt_d    = 8'd0;
            end
        end
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            haddr_q     <= 32'd0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef AHBM_TIMEOUT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = 3'b010;
    assign bus.HWDATA    = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Scoreboard bench for ahb_lite_cmd_master: random commands, a behavioural AHB slave, and a response monitor.
module tb_ahb_lite_cmd_master;
    localparam int TO = 4;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        logic        err;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          cyc;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic force_low = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    plan_t plan_q[$];
    exp_t  exp_q[$];

    ahb_lite_cmd_master_if bus();

    ahb_lite_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;
    initial forever begin @(posedge HCLK); cyc++; end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge HCLK); #1;
    endtask

    // Behavioural AHB slave: plays back the wait/error plan of each queued transfer.
    task automatic serve();
        plan_t p;
        logic [31:0] a;
        p = plan_q.pop_front();
        a = {p.addr[31:2], 2'b00};
        chk("haddr", bus.HADDR, a);
        chk("hwrite", bus.HWRITE, p.write);
        chk("hsize", bus.HSIZE, 3'b010);
        for (int i = 0; i < p.aw; i++) begin
            bus.HREADY = 1'b0;
            step();
            chk("addr_hold", {bus.HTRANS, bus.HWRITE, bus.HADDR}, {2'b10, p.write, a});
        end
        bus.HREADY = 1'b1;
        step();
        chk("data_htrans", bus.HTRANS, 2'b00);
        chk("hwdata", bus.HWDATA, p.write ? p.wdata : 32'd0);
        for (int i = 0; i < p.dw; i++) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = p.err && (i == p.dw - 1);
            step();
            chk("data_hold", {bus.HTRANS, bus.HWDATA}, {2'b00, p.write ? p.wdata : 32'd0});
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = p.err;
        bus.HRDATA = p.rdata;
        step();
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
    endtask

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            step();
            bus.HREADY = !force_low;
            if (!force_low && bus.HTRANS == 2'b10 && plan_q.size() > 0) serve();
        end
    end

    // Response monitor: every rsp_valid must match the oldest expectation, on its predicted cycle.
    initial begin
        exp_t e;
        forever begin
            step();
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("rsp_timeout", bus.rsp_timeout, e.to);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("ready_with_rsp", bus.cmd_ready, 1'b1);
                end
            end
        end
    end

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) chk("cmd_ready_wait", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        step();
        acc = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = $urandom_range(0, 1);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic issue(input plan_t p);
        exp_t e;
        int acc;
        plan_q.push_back(p);
        drive_cmd(p.write, p.addr, p.wdata, acc);
        e.rdata = (!p.write && !p.err) ? p.rdata : 32'd0;
        e.err   = p.err;
        e.to    = 1'b0;
        e.cyc   = acc + 2 + p.aw + p.dw;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || bus.cmd_ready !== 1'b1) && n < 500) begin step(); n++; end
        if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_htrans"}, bus.HTRANS, 2'b00);
        chk({nm, "_haddr"}, bus.HADDR, 32'd0);
        chk({nm, "_hwrite"}, bus.HWRITE, 1'b0);
        chk({nm, "_hwdata"}, bus.HWDATA, 32'd0);
        chk({nm, "_hsize"}, bus.HSIZE, 3'b010);
        chk({nm, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 35'd0);
        chk({nm, "_ready"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        plan_t p;
        int acc, seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        repeat (3) step();
        check_reset_vals("in_reset");
        HRESETn = 1'b1;
        step();
        check_reset_vals("after_reset");

        // Directed cases: plain write, read with data waits, address waits, error.
        p = '{1'b1, 32'h5300_0004, 32'h0000_0001, 32'h0, 0, 0, 1'b0}; issue(p);
        p = '{1'b0, 32'h5300_0000, 32'h1234_5678, 32'h0000_A5A5, 0, 2, 1'b0}; issue(p);
        p = '{1'b0, 32'h5300_0003, 32'h0, 32'hCAFE_0001, 3, 0, 1'b0}; issue(p);
        p = '{1'b0, 32'h6000_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, 1'b1}; issue(p);
        p = '{1'b1, 32'h6000_0008, 32'h5555_AAAA, 32'h0, 1, 2, 1'b1}; issue(p);

        for (int i = 0; i < 40; i++) begin
            p.write = $urandom_range(0, 1);
            p.addr  = $urandom;
            p.wdata = $urandom;
            p.rdata = $urandom;
            p.aw    = $urandom_range(0, 3);
            p.err   = ($urandom_range(0, 4) == 0);
            p.dw    = p.err ? $urandom_range(1, 3) : $urandom_range(0, 3);
            issue(p);
            repeat ($urandom_range(0, 2)) step();
        end
        drain();

        // HREADY stuck low with no slave plan.
        force_low = 1'b1;
        step();
        drive_cmd(1'b0, 32'h5300_0000, 32'h0, acc);
`ifdef AHBM_TIMEOUT_EN
        exp_q.push_back('{32'd0, 1'b1, 1'b1, acc + TO});
        repeat (TO - 1) step();
        chk("stuck_htrans_before_abort", bus.HTRANS, 2'b10);
        step();
        chk("abort_htrans", bus.HTRANS, 2'b00);
        chk("abort_ready", bus.cmd_ready, 1'b1);
        repeat (3) step();
        chk("abort_consumed", exp_q.size(), 0);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.rsp_valid === 1'b1) seen++;
        end
        chk("stuck_no_rsp", seen, 0);
        chk("stuck_htrans", bus.HTRANS, 2'b10);
        chk("stuck_busy", bus.cmd_ready, 1'b0);
`endif
        HRESETn = 1'b0;
        step();
        step();
        HRESETn = 1'b1;
        force_low = 1'b0;
        step();

        // Reset asserted in the data phase of a write: no response may follow.
        drive_cmd(1'b1, 32'h5300_0004, 32'hDEAD_BEEF, acc);
        step();
        chk("pre_reset_data_phase", {bus.HTRANS, bus.HWDATA}, {2'b00, 32'hDEAD_BEEF});
        HRESETn = 1'b0;
        #1;
        check_reset_vals("mid_xfer_reset");
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        step();
        chk("ready_after_reset", bus.cmd_ready, 1'b1);
        p = '{1'b0, 32'h5300_0000, 32'h0, 32'h0000_A5A5, 1, 1, 1'b0}; issue(p);
        drain();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
AHB-Lite single-transfer initiator for the peripheral subsystem. It converts a simple valid/ready command interface into NONSEQ word transfers and returns a one-cycle response pulse carrying read data and error status. It is the bus-side driver for the AHB peripherals (GPIO at 0x53000000/0x53000004). It sits between a test sequencer or microcode controller and the AHB decoder/mux.

Parameters:
TIMEOUT_CYCLES, 16, consecutive HREADY-low cycles tolerated before abort (used only with AHBM_TIMEOUT_EN); legal range 1..255

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command can be accepted
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  byte address, bits [1:0] ignored
cmd_wdata  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data (0 for writes/errors)
rsp_err  out  1  HRESP error or timeout
rsp_timeout  out  1  transfer aborted by timeout
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
HWRITE  out  1  AHB direction
HSIZE  out  3  fixed 3'b010 (word)
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HREADY  in  1  bus ready (from mux)
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, immediate): state IDLE; HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, HSIZE=010, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0. An in-flight transfer is dropped with no response.
- cmd_ready = (state==IDLE); all AHB outputs registered.
- States: IDLE -> ADDR on cmd_valid&&cmd_ready edge; command latched.
- ADDR: HTRANS=10, HADDR={cmd_addr[31:2],2'b00}, HWRITE=cmd_write. Held stable while HREADY=0. On edge with HREADY=1 -> DATA.
- DATA: HTRANS=00. HWDATA=latched wdata for writes, 0 for reads; held stable during waits. On edge with HREADY=1 -> IDLE, and in the next cycle rsp_valid=1 for exactly one cycle.
- rsp_rdata captures HRDATA at data-phase completion for OKAY reads; otherwise 0. rsp_* fields are held until the next response.
- Minimum latency: accept at edge E0, response visible after E2, and cmd_ready=1 again in the same cycle as rsp_valid. Each wait state adds one cycle.
- Error: HRESP=1 in DATA sets a sticky error flag. At completion (HREADY=1), rsp_err=1 and rsp_rdata=0. The first (HREADY=0) cycle of the two-cycle error response is treated as a wait state. The flag is cleared on accept.
- No back-to-back pipelining: HTRANS is never NONSEQ during DATA. HSEL is not driven (decoder owns it).
- cmd_* changes while not in IDLE are ignored.

Optional Feature:
AHBM_TIMEOUT_EN:
- Defined: an 8-bit counter increments on each cycle with HREADY=0 in ADDR or DATA, and resets on HREADY=1 or on accept. When the count reaches TIMEOUT_CYCLES:
  - force HTRANS=00 and go to IDLE;
  - the next cycle gives rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Undefined: no counter; the master waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Write 0x53000004 data 0x00000001 (HREADY=1) -> cycle after accept: HTRANS=10, HADDR=0x53000004, HWRITE=1. Next cycle: HTRANS=00, HWDATA=0x00000001. Next cycle: rsp_valid=1, rsp_err=0.
- Read 0x53000000 with GPIO returning HRDATA=0x0000A5A5, 2 wait states in data phase -> HWDATA=0 and stable through the waits. rsp_valid 4 edges after accept, rsp_rdata=0x0000A5A5.
- HREADY=0 for 3 cycles during the address phase -> HADDR/HTRANS/HWRITE unchanged for those cycles. Transfer completes normally.
- Error response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) on read of 0x60000000 -> rsp_err=1, rsp_rdata=0, cmd_ready=1 with rsp_valid.
- HRESETn low during DATA of a write -> outputs at reset values immediately, no rsp_valid. After release, cmd_ready=1 and a new read completes correctly.
- AHBM_TIMEOUT_EN, TIMEOUT_CYCLES=4, HREADY stuck 0 -> HTRANS=00 after 4 wait cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1. Without the macro, no response for 100 cycles.
